// File: rtl/frame_buffer_ctrl.sv
// Capture/playback controller for a simple dual-port frame buffer RAM.
// Writes one frame from a pixel stream, then replays it as a valid/ready stream.
module frame_buffer_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned FRAME_PIXELS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  input  logic              rd_start,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              frame_done,
  output logic              err_resync,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dia,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_dob
);

  // One extra counter bit so the terminal compare is exact at FRAME_PIXELS == 2**ADDR_W.
  localparam int unsigned     CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] LastPix = CntW'(FRAME_PIXELS - 1);
  localparam logic [CntW-1:0] NumPix  = CntW'(FRAME_PIXELS);

  typedef enum logic [1:0] {StIdle, StCapture, StFull, StPlayback} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wr_addr_q, wr_addr_d;
  logic [CntW-1:0] rd_addr_q, rd_addr_d;
  logic            m_valid_q, m_valid_d;
  logic            m_sof_q, m_sof_d;
  logic            m_eof_q, m_eof_d;
  logic            frame_done_q, frame_done_d;
  logic            err_resync_q, err_resync_d;

  logic accept, last_beat, issue, eof_hs;

  assign accept    = s_valid & s_ready;
  assign last_beat = (state_q == StCapture) & accept & ~s_sof & (wr_addr_q == LastPix);
  assign issue     = (state_q == StPlayback) & (rd_addr_q < NumPix) & (~m_valid_q | m_ready);
  assign eof_hs    = m_valid_q & m_ready & m_eof_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (accept && s_sof) state_d = StCapture;
      StCapture:  if (last_beat) state_d = StFull;
      StFull:     if (rd_start) state_d = StPlayback;
      StPlayback: if (eof_hs) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready   = (state_q == StIdle) || (state_q == StCapture);
    busy      = (state_q == StCapture) || (state_q == StPlayback);
    ram_ena   = 1'b0;
    ram_addra = '0;
    case (state_q)
      StIdle:    ram_ena = s_valid & s_sof;
      StCapture: begin
        ram_ena   = s_valid;
        ram_addra = s_sof ? '0 : wr_addr_q[ADDR_W-1:0];
      end
      default: ;
    endcase
    ram_wea   = ram_ena;
    ram_dia   = s_data;
    ram_enb   = issue;
    ram_addrb = rd_addr_q[ADDR_W-1:0];
  end

  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    m_valid_d    = m_valid_q;
    m_sof_d      = m_sof_q;
    m_eof_d      = m_eof_q;
    frame_done_d = last_beat;
    err_resync_d = (state_q == StCapture) & accept & s_sof;

    if (accept && s_sof) begin
      wr_addr_d = CntW'(1);
    end else if ((state_q == StCapture) && accept) begin
      wr_addr_d = wr_addr_q + CntW'(1);
    end

    if ((state_q == StFull) && rd_start) begin
      rd_addr_d = '0;
    end else if (issue) begin
      rd_addr_d = rd_addr_q + CntW'(1);
    end

    // Flags travel with the issued address; cleared once the last beat drains.
    if (issue) begin
      m_valid_d = 1'b1;
      m_sof_d   = (rd_addr_q == '0);
      m_eof_d   = (rd_addr_q == LastPix);
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_sof_d   = 1'b0;
      m_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      frame_done_q <= 1'b0;
      err_resync_q <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      m_valid_q    <= m_valid_d;
      m_sof_q      <= m_sof_d;
      m_eof_q      <= m_eof_d;
      frame_done_q <= frame_done_d;
      err_resync_q <= err_resync_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_sof      = m_sof_q;
  assign m_eof      = m_eof_q;
  assign m_data     = ram_dob;
  assign frame_done = frame_done_q;
  assign err_resync = err_resync_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: behavioural RAM, frame model built from the beats sent,
// randomized gaps, data and backpressure, with directed reset/resync/ignore scenarios.
module tb_frame_buffer_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int NPIX = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_sof, rd_start;
  logic [DW-1:0] s_data;
  logic          m_valid, m_ready, m_sof, m_eof;
  logic [DW-1:0] m_data;
  logic          frame_done, err_resync, busy;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia, ram_dob;

  always #5 clk = ~clk;

  frame_buffer_ctrl #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .FRAME_PIXELS(NPIX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .rd_start  (rd_start),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sof     (m_sof),
    .m_eof     (m_eof),
    .frame_done(frame_done),
    .err_resync(err_resync),
    .busy      (busy),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dia   (ram_dia),
    .ram_enb   (ram_enb),
    .ram_addrb (ram_addrb),
    .ram_dob   (ram_dob)
  );

  // Behavioural 1-cycle-latency simple dual-port RAM; output holds while ram_enb is low.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  int done_cnt = 0;
  int resync_cnt = 0;
  always @(posedge clk) begin
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    if (err_resync === 1'b1) resync_cnt <= resync_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as the spec says it should sit in the RAM.
  logic [DW-1:0] ref_frame [NPIX];
  int            ref_pos = 0;
  bit            capturing = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat (after an optional random idle gap); returns on the following negedge.
  task automatic beat(input logic [DW-1:0] d, input logic sof, input bit gap);
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    #1;
    chk("s_ready", s_ready, 1);
    if (sof) begin
      ref_pos   = 0;
      capturing = 1;
    end
    if (capturing) begin
      chk("ram_ena", ram_ena, 1);
      chk("ram_wea", ram_wea, 1);
      chk("ram_addra", ram_addra, ref_pos);
      chk("ram_dia", ram_dia, d);
      ref_frame[ref_pos] = d;
      ref_pos++;
      if (ref_pos == NPIX) capturing = 0;
    end else begin
      chk("ram_ena_drop", ram_ena, 0);
      chk("ram_wea_drop", ram_wea, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic after_capture(input int done_before);
    #1;
    chk("frame_done_pulse", frame_done, 1);
    chk("s_ready_full", s_ready, 0);
    chk("busy_full", busy, 0);
    @(negedge clk);
    #1;
    chk("frame_done_one_cycle", frame_done, 0);
    chk("frame_done_count", done_cnt - done_before, 1);
  endtask

  task automatic capture_random();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < NPIX; i++) beat(DW'($urandom), i == 0, 1);
    after_capture(d0);
  endtask

  // mode 0: m_ready=1; mode 1: pattern 1,0,0,1,1,0; mode 2: random. abort_at>=0 resets there.
  task automatic playback(input int mode, input int abort_at);
    bit            pat [6] = '{1, 0, 0, 1, 1, 0};
    int            out_idx = 0;
    int            cyc = 0;
    bit            stalled = 0;
    logic [DW-1:0] last_d = '0;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    while (out_idx < NPIX && cyc < 20 * NPIX) begin
      cyc++;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[(cyc - 1) % 6];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) begin
        chk("busy_playback", busy, 1);
        chk("m_valid_lat1", m_valid, 0);
        chk("ram_enb_first", ram_enb, 1);
        chk("ram_addrb_first", ram_addrb, 0);
      end
      if (cyc == 2) chk("m_valid_lat2", m_valid, 1);
      if (m_valid === 1'b1) begin
        if (abort_at >= 0 && out_idx == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_m_valid", m_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_s_ready", s_ready, 1);
          chk("rst_ram_enb", ram_enb, 0);
          chk("rst_ram_addrb", ram_addrb, 0);
          chk("rst_m_sof", m_sof, 0);
          chk("rst_m_eof", m_eof, 0);
          @(negedge clk);
          rst_n   = 1'b1;
          m_ready = 1'b0;
          capturing = 0;
          return;
        end
        chk("m_data", m_data, ref_frame[out_idx]);
        chk("m_sof", m_sof, out_idx == 0);
        chk("m_eof", m_eof, out_idx == NPIX - 1);
        if (stalled) chk("stall_hold", m_data, last_d);
        if (!m_ready) chk("stall_no_read", ram_enb, 0);
        stalled = !m_ready;
        last_d  = m_data;
        if (m_ready) out_idx++;
      end
      @(negedge clk);
    end
    m_ready = 1'b0;
    if (out_idx < NPIX) chk("playback_timeout", out_idx, NPIX);
    #1;
    chk("idle_after_eof", busy, 0);
    chk("s_ready_after_eof", s_ready, 1);
    chk("m_valid_after_eof", m_valid, 0);
    if (mode == 0) chk("playback_cycles", cyc, NPIX + 1);
  endtask

  initial begin
    int d0, r0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_sof    = 1'b0;
    s_data   = '0;
    rd_start = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_s_ready", s_ready, 1);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_err_resync", err_resync, 0);
    chk("reset_ram_ena", ram_ena, 0);
    chk("reset_ram_enb", ram_enb, 0);
    chk("reset_ram_addra", ram_addra, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ignored inputs in IDLE: data without sof, and rd_start.
    for (int i = 0; i < 5; i++) beat(DW'(16'h0BAD + i), 1'b0, 0);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    #1;
    chk("rd_start_idle_busy", busy, 0);
    chk("rd_start_idle_ready", s_ready, 1);
    @(negedge clk);

    // Basic frame with index data; rd_start pulsed mid-capture must be ignored.
    d0 = done_cnt;
    for (int i = 0; i < NPIX; i++) begin
      rd_start = (i == 10);
      beat(DW'(i), i == 0, 1);
      if (i == 10) begin
        #1;
        chk("rd_start_capture_busy", busy, 1);
        chk("rd_start_capture_ready", s_ready, 1);
        @(negedge clk);
      end
    end
    rd_start = 1'b0;
    after_capture(d0);
    playback(0, -1);

    // Backpressure with the fixed stall pattern on random data.
    capture_random();
    playback(1, -1);

    // Resync: restart at beat 500 with data 1000+k.
    d0 = done_cnt;
    r0 = resync_cnt;
    for (int i = 0; i < 500; i++) beat(DW'(i), i == 0, 1);
    for (int k = 0; k < NPIX; k++) begin
      if (k == NPIX - 1) chk("resync_no_early_done", done_cnt - d0, 0);
      beat(DW'(1000 + k), k == 0, 1);
      if (k == 0) begin
        #1;
        chk("err_resync_pulse", err_resync, 1);
        @(negedge clk);
      end
    end
    after_capture(d0);
    chk("err_resync_count", resync_cnt - r0, 1);
    playback(2, -1);

    // Reset in the middle of playback, then a full clean frame.
    capture_random();
    playback(0, 300);
    capture_random();
    playback(2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
